// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: byte-FSM encodings, bit timing, word split.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional parity state is present only with UART_WORD_TX_PARITY_EN.
package uart_pkg;

   // Every start, data and parity bit spans this many oversampling ticks.
   localparam int TICKS_PER_BIT = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_WORD_TX_PARITY_EN
      ST_PARITY = 3'd4,
`endif
      ST_STOP   = 3'd3
   } tx_state_e;

   // Number of UART frames needed for one word; the word width must be a
   // whole multiple of the frame data width.
   function automatic int nbytes(input int nbits_d, input int dbit);
      return nbits_d / dbit;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// Single-byte UART serializer: start, DBIT data bits LSB first, optional even parity, stop.
// Latency: line goes low the cycle after i_tx_start; o_tx_done_tick fires in the cycle the stop bit ends.
// Backpressure: i_tx_start honoured in IDLE or in the final stop cycle (gapless chaining); ignored otherwise.
import uart_pkg::*;

module uart_tx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_s_tick,
   input  logic            i_tx_start,
   input  logic [DBIT-1:0] i_din,
   output logic            o_tx_done_tick,
   output logic            o_tx
);

   localparam int TW = $clog2((SB_TICK > TICKS_PER_BIT) ? SB_TICK : TICKS_PER_BIT);
   localparam int NW = $clog2(DBIT + 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(TICKS_PER_BIT - 1);
   localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

   tx_state_e       state_q, state_d;
   logic [TW-1:0]   s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic            tx_q, tx_d;
`ifdef UART_WORD_TX_PARITY_EN
   logic            par_q, par_d;
`endif

   // Next-state logic; the line value is derived from the next state so that
   // the tx register always matches the state register and never glitches.
   always_comb begin
      state_d        = state_q;
      s_d            = s_q;
      n_d            = n_q;
      b_d            = b_q;
      o_tx_done_tick = 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
      par_d          = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_tx_start) begin
               state_d = ST_START;
               s_d     = '0;
               b_d     = i_din;
`ifdef UART_WORD_TX_PARITY_EN
               par_d   = ^i_din;
`endif
            end
         end
         ST_START: begin
            if (i_s_tick) begin
               if (s_q == BIT_LAST) begin
                  state_d = ST_DATA;
                  s_d     = '0;
                  n_d     = '0;
               end else begin
                  s_d = s_q + TW'(1);
               end
            end
         end
         ST_DATA: begin
            if (i_s_tick) begin
               if (s_q == BIT_LAST) begin
                  s_d = '0;
                  b_d = b_q >> 1;
                  if (n_q == N_LAST) begin
`ifdef UART_WORD_TX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end else begin
                  s_d = s_q + TW'(1);
               end
            end
         end
`ifdef UART_WORD_TX_PARITY_EN
         ST_PARITY: begin
            if (i_s_tick) begin
               if (s_q == BIT_LAST) begin
                  state_d = ST_STOP;
                  s_d     = '0;
               end else begin
                  s_d = s_q + TW'(1);
               end
            end
         end
`endif
         ST_STOP: begin
            if (i_s_tick) begin
               if (s_q == STOP_LAST) begin
                  o_tx_done_tick = 1'b1;
                  s_d            = '0;
                  // A pending start chains straight into the next frame.
                  if (i_tx_start) begin
                     state_d = ST_START;
                     b_d     = i_din;
`ifdef UART_WORD_TX_PARITY_EN
                     par_d   = ^i_din;
`endif
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_d = s_q + TW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = b_d[0];
`ifdef UART_WORD_TX_PARITY_EN
         ST_PARITY: tx_d = par_d;
`endif
         default:   tx_d = 1'b1;
      endcase
   end

   // State, counters, shift register and line register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         tx_q    <= 1'b1;
`ifdef UART_WORD_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         tx_q    <= tx_d;
`ifdef UART_WORD_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign o_tx = tx_q;

endmodule

// File: rtl/uart_word_tx.sv
// Word UART transmitter: sends an NBITS_D word as NBITS_D/DBIT frames, low byte first, back to back.
// Latency: first start bit the cycle after accept; o_tx_done one cycle after the final stop bit; o_ready one cycle later.
// Backpressure: o_ready low from accept until after o_tx_done; i_valid while busy is ignored. Parity via UART_WORD_TX_PARITY_EN.
import uart_pkg::*;

module uart_word_tx #(
   parameter int NBITS_D = 16,
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_s_tick,
   input  logic               i_valid,
   input  logic [NBITS_D-1:0] i_data,
   output logic               o_ready,
   output logic               o_tx,
   output logic               o_tx_done
);

   localparam int NBYTES = nbytes(NBITS_D, DBIT);
   localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   // word_q holds the bytes not yet handed to the serializer, low byte first.
   logic [NBITS_D-1:0] word_q, word_d;
   logic [BW-1:0]      rem_q, rem_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
   logic               accept;
   logic               tx_start;
   logic [DBIT-1:0]    tx_din;
   logic               byte_done;

   assign accept = i_valid & ready_q;

   // Byte sequencing: load on accept, feed the next byte as each frame ends,
   // flag completion after the last one, then reopen the input a cycle later.
   always_comb begin
      word_d   = word_q;
      rem_d    = rem_q;
      ready_d  = ready_q;
      done_d   = 1'b0;
      tx_start = 1'b0;
      tx_din   = word_q[DBIT-1:0];
      if (accept) begin
         tx_start = 1'b1;
         tx_din   = i_data[DBIT-1:0];
         word_d   = i_data >> DBIT;
         rem_d    = BW'(NBYTES - 1);
         ready_d  = 1'b0;
      end else if (byte_done) begin
         if (rem_q == '0) begin
            done_d = 1'b1;
         end else begin
            tx_start = 1'b1;
            word_d   = word_q >> DBIT;
            rem_d    = rem_q - BW'(1);
         end
      end else if (done_q) begin
         ready_d = 1'b1;
      end
   end

   // Sequencer registers; reset discards any partially sent word.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         word_q  <= '0;
         rem_q   <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         word_q  <= word_d;
         rem_q   <= rem_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   uart_tx #(
      .DBIT    (DBIT),
      .SB_TICK (SB_TICK)
   ) u_tx (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_s_tick       (i_s_tick),
      .i_tx_start     (tx_start),
      .i_din          (tx_din),
      .o_tx_done_tick (byte_done),
      .o_tx           (o_tx)
   );

   assign o_ready   = ready_q;
   assign o_tx_done = done_q;

endmodule
